// File: rtl/phase_seq_monitor.sv
// phase_seq_monitor: locks onto the 0-1-2-3 phase rotation and flags violations; PHASE_BIT_CHECK_EN adds the bit_in check
module phase_seq_monitor #(
  parameter int LOCK_LEN = 4,
  parameter int CNT_W = 8,
  parameter int WRAP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        phase_in,
  input  logic              bit_in,
  input  logic              clr_err,
  output logic              locked,
  output logic              seq_err,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_count,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              wrap_pulse
);
  localparam int GW = LOCK_LEN > 1 ? $clog2(LOCK_LEN) : 1;
  localparam logic [1:0] ACQUIRE = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2;
  logic [1:0] state, prev_phase;
  logic [GW-1:0] good_cnt;
  logic good, viol, wrap, last;
`ifdef PHASE_BIT_CHECK_EN
  assign good = phase_in == prev_phase + 2'd1 && bit_in == ~phase_in[0];
`else
  logic unused_bit;
  assign unused_bit = bit_in;
  assign good = phase_in == prev_phase + 2'd1;
`endif
  assign viol = en && state == LOCKED && !good;
  assign wrap = en && state == LOCKED && good && prev_phase == 2'd3;
  assign last = 32'(good_cnt) + 1 == LOCK_LEN;
  assign locked = state == LOCKED;
  // sequence tracking: acquire, count consecutive good samples, hold lock until a bad one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACQUIRE;
      prev_phase <= '0;
      good_cnt <= '0;
    end else if (en) begin
      prev_phase <= phase_in;
      if (state == ACQUIRE || !good) begin
        good_cnt <= '0;
        state <= VERIFY;
      end else if (state == VERIFY) begin
        if (last) state <= LOCKED;
        else good_cnt <= good_cnt + 1'b1;
      end
    end
  end
  // status: pulses, sticky flag, saturating error count and rotation count; a violation beats clr_err
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_err <= 1'b0;
      wrap_pulse <= 1'b0;
      err_sticky <= 1'b0;
      err_count <= '0;
      wrap_count <= '0;
    end else begin
      seq_err <= viol;
      wrap_pulse <= wrap;
      err_sticky <= viol || (err_sticky && !clr_err);
      err_count <= viol ? (clr_err ? CNT_W'(1) : (&err_count ? err_count : err_count + 1'b1)) :
                   clr_err ? '0 : err_count;
      if (wrap) wrap_count <= wrap_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_phase_seq_monitor.sv
// tb_phase_seq_monitor: randomized and directed checks of phase_seq_monitor against a run-length reference model
module tb_phase_seq_monitor;
  localparam int LOCK_LEN = 4;
`ifdef PHASE_BIT_CHECK_EN
  localparam bit BIT_CHK = 1'b1;
`else
  localparam bit BIT_CHK = 1'b0;
`endif
  logic clk = 0, rst = 0, en = 0, bit_in = 0, clr_err = 0;
  logic [1:0] phase_in = 0;
  logic locked, seq_err, err_sticky, wrap_pulse;
  logic [7:0] err_count;
  logic [15:0] wrap_count;
  int total = 0, bad = 0;
  bit m_acq, m_locked, m_seq, m_wp, m_sticky;
  int m_run, m_prev, m_cnt, m_wrap;

  always #5 clk = ~clk;

  phase_seq_monitor #(.LOCK_LEN(LOCK_LEN), .CNT_W(8), .WRAP_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .phase_in(phase_in), .bit_in(bit_in), .clr_err(clr_err),
    .locked(locked), .seq_err(seq_err), .err_sticky(err_sticky), .err_count(err_count),
    .wrap_count(wrap_count), .wrap_pulse(wrap_pulse)
  );

  function automatic bit right_bit(int p);
    return (p % 2) == 0;
  endfunction

  function automatic bit is_good(int ph, bit b, int prev);
    return ph == (prev + 1) % 4 && (!BIT_CHK || b == right_bit(ph));
  endfunction

  function automatic logic [27:0] dut_vec();
    return {locked, seq_err, wrap_pulse, err_sticky, err_count, wrap_count};
  endfunction

  function automatic logic [27:0] mdl_vec();
    return {m_locked, m_seq, m_wp, m_sticky, 8'(m_cnt), 16'(m_wrap)};
  endfunction

  task automatic model_reset();
    m_acq = 0; m_locked = 0; m_seq = 0; m_wp = 0; m_sticky = 0;
    m_run = 0; m_prev = 0; m_cnt = 0; m_wrap = 0;
  endtask

  task automatic cycle(input bit e, input int ph, input bit b, input bit clr);
    bit g, v;
    en = e; phase_in = 2'(ph); bit_in = b; clr_err = clr;
    @(posedge clk);
    v = 0; m_wp = 0;
    if (e) begin
      if (!m_acq) begin
        m_acq = 1; m_run = 0;
      end else begin
        g = is_good(ph, b, m_prev);
        v = m_locked && !g;
        if (m_locked && g && m_prev == 3) begin
          m_wp = 1; m_wrap = (m_wrap + 1) % 65536;
        end
        m_run = g ? m_run + 1 : 0;
        m_locked = m_run >= LOCK_LEN;
      end
      m_prev = ph;
    end
    m_seq = v;
    if (v) begin
      m_sticky = 1; m_cnt = clr ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
    end else if (clr) begin
      m_sticky = 0; m_cnt = 0;
    end
    #1;
  endtask

  task automatic good_sample();
    int p;
    p = (m_prev + 1) % 4;
    cycle(1, p, right_bit(p), 0);
  endtask

  task automatic bad_sample(input bit clr);
    int p;
    p = (m_prev + 2 + int'($urandom_range(0, 2))) % 4;
    cycle(1, p, right_bit(p), clr);
  endtask

  task automatic relock();
    while (!m_locked) good_sample();
  endtask

  task automatic test_reset();
    rst = 1; #3;
    @(posedge clk); #1;
    model_reset();
    total++; if (dut_vec() !== 28'd0) begin bad++; $display("FAIL reset_outputs got=%h want=0", dut_vec()); end
    en = 1; phase_in = 1; @(posedge clk); #1;
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_hold locked got=%b want=0", locked); end
    rst = 0;
  endtask

  task automatic test_lock();
    int ph[5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      cycle(1, ph[i], right_bit(ph[i]), 0);
      total++; if (locked !== (i == 4)) begin bad++; $display("FAIL lock_step%0d got=%b want=%b", i, locked, i == 4); end
    end
    total++; if (wrap_count !== 16'd0 || err_count !== 8'd0) begin bad++; $display("FAIL lock_counts wrap=%0d err=%0d want=0,0", wrap_count, err_count); end
  endtask

  task automatic test_rotation();
    int pulses = 0;
    for (int i = 0; i < 32; i++) begin
      good_sample();
      pulses += int'(wrap_pulse);
      total++; if (wrap_pulse !== m_wp) begin bad++; $display("FAIL rot_pulse%0d got=%b want=%b", i, wrap_pulse, m_wp); end
    end
    total++; if (wrap_count !== 16'd8 || pulses != 8) begin bad++; $display("FAIL rot_count wrap=%0d pulses=%0d want=8,8", wrap_count, pulses); end
  endtask

  task automatic test_skip();
    cycle(1, 1, 0, 0);
    cycle(1, 3, 0, 0);
    total++; if ({seq_err, err_sticky, err_count, locked} !== {1'b1, 1'b1, 8'd1, 1'b0}) begin
      bad++; $display("FAIL skip seq=%b sticky=%b cnt=%0d locked=%b want=1,1,1,0", seq_err, err_sticky, err_count, locked); end
    cycle(0, 2, 0, 0);
    total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL skip_pulse_width got=%b want=0", seq_err); end
    for (int i = 0; i < 4; i++) begin
      good_sample();
      total++; if (locked !== (i == 3)) begin bad++; $display("FAIL relock%0d got=%b want=%b", i, locked, i == 3); end
    end
  endtask

  task automatic test_bit_err();
    cycle(0, 0, 0, 1);
    while (m_prev != 1) good_sample();
    cycle(1, 2, 0, 0);
    total++; if ({seq_err, err_count, locked} !== {BIT_CHK, 8'(BIT_CHK), !BIT_CHK}) begin
      bad++; $display("FAIL bit_err seq=%b cnt=%0d locked=%b want=%b,%0d,%b", seq_err, err_count, locked, BIT_CHK, BIT_CHK, !BIT_CHK); end
  endtask

  task automatic test_clear();
    cycle(0, 0, 0, 1);
    total++; if ({err_sticky, err_count} !== 9'd0) begin bad++; $display("FAIL clr_first sticky=%b cnt=%0d want=0,0", err_sticky, err_count); end
    for (int i = 0; i < 5; i++) begin relock(); bad_sample(0); end
    total++; if (err_count !== 8'd5) begin bad++; $display("FAIL clr_five got=%0d want=5", err_count); end
    relock(); bad_sample(1);
    total++; if ({err_sticky, err_count} !== {1'b1, 8'd1}) begin bad++; $display("FAIL clr_vs_err sticky=%b cnt=%0d want=1,1", err_sticky, err_count); end
    cycle(0, 3, 0, 1);
    total++; if ({err_sticky, err_count} !== 9'd0) begin bad++; $display("FAIL clr_alone sticky=%b cnt=%0d want=0,0", err_sticky, err_count); end
  endtask

  task automatic test_en_gap();
    relock(); good_sample();
    for (int i = 0; i < 10; i++) begin
      cycle(0, int'($urandom_range(0, 3)), 1'($urandom), 0);
      total++; if ({seq_err, locked} !== 2'b01) begin bad++; $display("FAIL gap%0d seq=%b locked=%b want=0,1", i, seq_err, locked); end
    end
    good_sample();
    total++; if ({seq_err, locked, err_count} !== {2'b01, 8'(m_cnt)}) begin bad++; $display("FAIL gap_resume seq=%b locked=%b cnt=%0d", seq_err, locked, err_count); end
  endtask

  task automatic test_saturation();
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 260; i++) begin relock(); bad_sample(0); end
    total++; if ({seq_err, err_sticky, err_count} !== {2'b11, 8'hff}) begin
      bad++; $display("FAIL saturate seq=%b sticky=%b cnt=%0d want=1,1,255", seq_err, err_sticky, err_count); end
  endtask

  task automatic test_random();
    int r, p;
    bit e, b;
    for (int i = 0; i < 3000; i++) begin
      e = $urandom_range(0, 3) != 0;
      r = int'($urandom_range(0, 99));
      p = r < 90 ? (m_prev + 1) % 4 : int'($urandom_range(0, 3));
      b = $urandom_range(0, 99) < 3 ? !right_bit(p) : right_bit(p);
      cycle(e, p, b, $urandom_range(0, 99) < 2);
      total++; if (dut_vec() !== mdl_vec()) begin bad++; $display("FAIL random%0d got=%h want=%h", i, dut_vec(), mdl_vec()); end
    end
  endtask

  task automatic test_async_reset();
    relock();
    for (int i = 0; i < 8; i++) good_sample();
    bad_sample(0);
    #2 rst = 1;
    #1;
    total++; if (dut_vec() !== 28'd0) begin bad++; $display("FAIL async_reset got=%h want=0", dut_vec()); end
    model_reset();
    #2 rst = 0;
    for (int i = 0; i < LOCK_LEN + 1; i++) good_sample();
    total++; if (dut_vec() !== mdl_vec()) begin bad++; $display("FAIL post_reset_lock got=%h want=%h", dut_vec(), mdl_vec()); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_rotation();
    test_skip();
    test_bit_err();
    test_clear();
    test_en_gap();
    test_saturation();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
